// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: phase encodings seen by the ALU, LSU,
// PC unit, fetcher and scheduler.
package gpu_pkg;

    localparam int PC_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_FETCH   = 3'b001,
        ST_DECODE  = 3'b010,
        ST_REQUEST = 3'b011,
        ST_WAIT    = 3'b100,
        ST_EXECUTE = 3'b101,
        ST_UPDATE  = 3'b110,
        ST_DONE    = 3'b111
    } core_state_t;

endpackage

// File: rtl/core_scheduler_if.sv
// Scheduler control bus: the scheduler is master, fetcher/LSU/PC/ALU
// side is slave.
interface core_scheduler_if #(
    parameter int THREADS = 4
);
    import gpu_pkg::*;

    logic               start;
    logic               instr_valid;
    logic [THREADS-1:0] lsu_busy;
    logic               decoded_ret;
    logic [PC_W-1:0]    next_pc;
    logic [2:0]         core_state;
    logic               instr_req;
    logic [PC_W-1:0]    current_pc;
    logic               done;
    logic               timeout_err;

    modport master (
        input  start, instr_valid, lsu_busy, decoded_ret, next_pc,
        output core_state, instr_req, current_pc, done, timeout_err
    );

    modport slave (
        output start, instr_valid, lsu_busy, decoded_ret, next_pc,
        input  core_state, instr_req, current_pc, done, timeout_err
    );

endinterface

// File: rtl/sched_wait_timer.sv
// WAIT-phase watchdog: counts busy WAIT cycles and flags the cycle in
// which the count reaches LIMIT.
module sched_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expire = inc && (cnt == LAST);

endmodule

// File: rtl/core_scheduler.sv
// GPU core phase scheduler. Define SCHED_TIMEOUT_EN to add a WAIT-phase
// watchdog that ends the block with timeout_err after TIMEOUT_CYCLES.
module core_scheduler
    import gpu_pkg::*;
#(
    parameter int THREADS        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    core_scheduler_if.master  bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_limit
        $error("TIMEOUT_CYCLES must fit the 8-bit wait counter");
    end

    core_state_t        state;
    core_state_t        nxt;
    logic [PC_W-1:0]    pc;
    logic               done_q;
    logic [THREADS-1:0] busy;
    logic               any_busy;
    logic               expire;

    assign busy     = bus.lsu_busy;
    assign any_busy = |busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            pc     <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= nxt;
            done_q <= (nxt == ST_DONE);
            if (state == ST_IDLE && bus.start) begin
                pc <= '0;
            end else if (state == ST_UPDATE && !bus.decoded_ret) begin
                pc <= bus.next_pc;
            end
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE:    if (bus.start) nxt = ST_FETCH;
            ST_FETCH:   if (bus.instr_valid) nxt = ST_DECODE;
            ST_DECODE:  nxt = ST_REQUEST;
            ST_REQUEST: nxt = ST_WAIT;
            ST_WAIT: begin
                if (!any_busy)   nxt = ST_EXECUTE;
                else if (expire) nxt = ST_DONE;
            end
            ST_EXECUTE: nxt = ST_UPDATE;
            ST_UPDATE:  nxt = bus.decoded_ret ? ST_DONE : ST_FETCH;
            ST_DONE:    nxt = ST_DONE;
            default:    nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.instr_req  = (state == ST_FETCH);
        bus.core_state = state;
        bus.current_pc = pc;
        bus.done       = done_q;
    end

`ifdef SCHED_TIMEOUT_EN
    logic terr_q;

    // Cleared in REQUEST so every WAIT visit starts counting from zero.
    sched_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_REQUEST),
        .inc    (state == ST_WAIT && any_busy),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            terr_q <= 1'b0;
        end else if (expire) begin
            terr_q <= 1'b1;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    assign expire          = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
// Directed scoreboard bench for core_scheduler: the driver queues the
// expected phase/pc/flags after each edge, a monitor checks them.
module tb_core_scheduler;
    import gpu_pkg::*;

    typedef struct {
        logic [2:0] st;
        logic [7:0] pc;
        logic       dn;
        logic       rq;
        logic       te;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    core_scheduler_if #(.THREADS(4)) bus ();

    core_scheduler #(
        .THREADS        (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t  q[$];
    string nq[$];
    int    vecs = 0;
    int    errs = 0;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_FET  = 3'b001;
    localparam logic [2:0] S_DEC  = 3'b010;
    localparam logic [2:0] S_REQ  = 3'b011;
    localparam logic [2:0] S_WAIT = 3'b100;
    localparam logic [2:0] S_EXE  = 3'b101;
    localparam logic [2:0] S_UPD  = 3'b110;
    localparam logic [2:0] S_DONE = 3'b111;

    task automatic cyc(input string nm, input logic [2:0] st,
                       input logic [7:0] pc, input logic dn,
                       input logic te);
        exp_t e;
        @(posedge clk);
        #1;
        e.st = st;
        e.pc = pc;
        e.dn = dn;
        e.rq = (st == S_FET);
        e.te = te;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    // One non-memory instruction, starting and ending in FETCH.
    task automatic instr(input logic [7:0] pc, input logic [7:0] npc);
        bus.next_pc = npc;
        cyc("decode",  S_DEC,  pc,  1'b0, 1'b0);
        cyc("request", S_REQ,  pc,  1'b0, 1'b0);
        cyc("wait",    S_WAIT, pc,  1'b0, 1'b0);
        cyc("execute", S_EXE,  pc,  1'b0, 1'b0);
        cyc("update",  S_UPD,  pc,  1'b0, 1'b0);
        cyc("refetch", S_FET,  npc, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e  = q.pop_front();
                nm = nq.pop_front();
                vecs++;
                if (bus.core_state !== e.st || bus.current_pc !== e.pc ||
                    bus.done !== e.dn || bus.instr_req !== e.rq ||
                    bus.timeout_err !== e.te) begin
                    errs++;
                    $display("FAIL %s: got st=%b pc=%0d done=%b req=%b terr=%b, want st=%b pc=%0d done=%b req=%b terr=%b",
                             nm, bus.core_state, bus.current_pc, bus.done,
                             bus.instr_req, bus.timeout_err,
                             e.st, e.pc, e.dn, e.rq, e.te);
                end
            end
        end
    end

    initial begin : driver
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.instr_valid = 1'b0;
        bus.lsu_busy    = 4'b0000;
        bus.decoded_ret = 1'b0;
        bus.next_pc     = 8'd0;

        cyc("reset", S_IDLE, 8'd0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc("idle_hold", S_IDLE, 8'd0, 1'b0, 1'b0);
        cyc("idle_hold", S_IDLE, 8'd0, 1'b0, 1'b0);

        bus.start       = 1'b1;
        bus.instr_valid = 1'b1;
        cyc("start", S_FET, 8'd0, 1'b0, 1'b0);
        bus.start = 1'b0;
        instr(8'd0, 8'd1);
        instr(8'd1, 8'd2);
        instr(8'd2, 8'd3);

        bus.instr_valid = 1'b0;
        repeat (10) cyc("fetch_stall", S_FET, 8'd3, 1'b0, 1'b0);
        bus.instr_valid = 1'b1;
        cyc("stall_decode", S_DEC, 8'd3, 1'b0, 1'b0);
        cyc("request", S_REQ, 8'd3, 1'b0, 1'b0);
        bus.lsu_busy = 4'b0010;
        cyc("wait_busy", S_WAIT, 8'd3, 1'b0, 1'b0);
        repeat (5) cyc("wait_busy", S_WAIT, 8'd3, 1'b0, 1'b0);
        bus.lsu_busy = 4'b0000;
        cyc("busy_clear", S_EXE, 8'd3, 1'b0, 1'b0);
        bus.decoded_ret = 1'b1;
        cyc("update_ret", S_UPD, 8'd3, 1'b0, 1'b0);
        bus.next_pc = 8'h77;
        cyc("ret_done", S_DONE, 8'd3, 1'b1, 1'b0);
        bus.start    = 1'b1;
        bus.lsu_busy = 4'b1111;
        cyc("done_absorb", S_DONE, 8'd3, 1'b1, 1'b0);
        cyc("done_absorb", S_DONE, 8'd3, 1'b1, 1'b0);
        bus.start    = 1'b0;
        bus.lsu_busy = 4'b0000;

        reset           = 1'b1;
        bus.decoded_ret = 1'b0;
        cyc("reset_done", S_IDLE, 8'd0, 1'b0, 1'b0);
        reset = 1'b0;

        bus.start = 1'b1;
        cyc("start2", S_FET, 8'd0, 1'b0, 1'b0);
        bus.start = 1'b0;
        instr(8'd0, 8'd1);
        cyc("decode", S_DEC, 8'd1, 1'b0, 1'b0);
        cyc("request", S_REQ, 8'd1, 1'b0, 1'b0);
        bus.lsu_busy = 4'b1111;
        cyc("wait_all", S_WAIT, 8'd1, 1'b0, 1'b0);
        cyc("wait_all", S_WAIT, 8'd1, 1'b0, 1'b0);
        reset = 1'b1;
        cyc("reset_wait", S_IDLE, 8'd0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc("idle_no_start", S_IDLE, 8'd0, 1'b0, 1'b0);
        bus.lsu_busy = 4'b0000;

        bus.start = 1'b1;
        cyc("start3", S_FET, 8'd0, 1'b0, 1'b0);
        bus.start = 1'b0;
        instr(8'd0, 8'hFF);
        instr(8'hFF, 8'h00);

        cyc("decode", S_DEC, 8'd0, 1'b0, 1'b0);
        cyc("request", S_REQ, 8'd0, 1'b0, 1'b0);
        bus.lsu_busy = 4'b1000;
        cyc("wait_to", S_WAIT, 8'd0, 1'b0, 1'b0);
`ifdef SCHED_TIMEOUT_EN
        repeat (7) cyc("wait_to", S_WAIT, 8'd0, 1'b0, 1'b0);
        cyc("timeout", S_DONE, 8'd0, 1'b1, 1'b1);
        bus.lsu_busy = 4'b0000;
        cyc("terr_sticky", S_DONE, 8'd0, 1'b1, 1'b1);
`else
        repeat (12) cyc("wait_nolimit", S_WAIT, 8'd0, 1'b0, 1'b0);
        bus.lsu_busy = 4'b0000;
        cyc("wait_release", S_EXE, 8'd0, 1'b0, 1'b0);
`endif
        reset = 1'b1;
        cyc("reset_end", S_IDLE, 8'd0, 1'b0, 1'b0);
        reset = 1'b0;

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
